// File: rtl/hash_arb_pkg.sv
// hash_arb_pkg
//   Shared types and helpers for the hash request arbiter slice.
//   - KEY_WIDTH        : width of a requester key
//   - hash_resp_t      : one buffered response {id, key, hash}; the id and hash
//                        fields are sized for the largest supported build and
//                        the top uses only the low bits it needs
//   - rr_pick()        : round-robin search for the first asserted valid at or
//                        after a pointer, wrapping modulo the requester count
package hash_arb_pkg;

  localparam int KEY_WIDTH       = 32;
  localparam int MAX_REQ         = 32;
  localparam int RESP_ID_MAX_W   = 8;
  localparam int RESP_HASH_MAX_W = 32;

  typedef struct packed {
    logic [RESP_ID_MAX_W-1:0]   id;
    logic [KEY_WIDTH-1:0]       key;
    logic [RESP_HASH_MAX_W-1:0] hash;
  } hash_resp_t;

  // The wrap is done with a single subtraction instead of a modulo because
  // ptr and the offset are both below numReq, so their sum is below 2*numReq.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned        ptr,
                                          input int unsigned        numReq);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= numReq) idx = idx - numReq;
      if (!found && (i < numReq) && valid[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/Hashing_Unit.sv
// Hashing_Unit
//   Fixed-latency multiplicative hash of a 32-bit key. The hash is the top
//   HASH_WIDTH bits of key * 0x9E3779B1 (mod 2^32), delayed by HASH_LATENCY
//   register stages.
//   Ports:
//     clock      in  rising-edge clock
//     reset      in  synchronous active-high reset, clears the pipeline
//     key        in  KEY_WIDTH key presented this cycle
//     hash_value out hash of the key presented HASH_LATENCY cycles earlier
module Hashing_Unit
  import hash_arb_pkg::*;
#(
  parameter int NUM_ENTRIES_PER_HASH_TABLE = 256,
  parameter int HASH_LATENCY               = 1
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [KEY_WIDTH-1:0]                          key,
  output logic [$clog2(NUM_ENTRIES_PER_HASH_TABLE)-1:0] hash_value
);

  localparam int HASH_W = $clog2(NUM_ENTRIES_PER_HASH_TABLE);

  logic [31:0]       w_product;
  logic [HASH_W-1:0] w_hash;
  logic              w_unusedProduct;
  logic [HASH_W-1:0] r_stage [HASH_LATENCY];

  // The upper product bits mix every key bit, so they make the index.
  always_comb begin
    w_product       = key * 32'h9E37_79B1;
    w_hash          = w_product[31 -: HASH_W];
    w_unusedProduct = ^w_product;
  end

  // Delay line that sets the fixed latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < HASH_LATENCY; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= w_hash;
      for (int s = 1; s < HASH_LATENCY; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign hash_value = r_stage[HASH_LATENCY-1];

endmodule

// File: rtl/hash_rr_arbiter.sv
// hash_rr_arbiter
//   Round-robin grant among NUM_REQ requesters, gated by the credit check.
//   Ports:
//     clock       in  rising-edge clock
//     reset       in  synchronous active-high reset, pointer back to 0
//     i_reqValid  in  per-requester valid
//     i_issueOk   in  a response slot is free for one more key
//     o_grant     out one-hot grant (zero when nothing can be issued)
//     o_grantIdx  out index of the winning requester
//     o_transfer  out a key is accepted this cycle
module hash_rr_arbiter
  import hash_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         i_reqValid,
  input  logic                       i_issueOk,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grantIdx,
  output logic                       o_transfer
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] r_rrPtr;
  int unsigned     w_pick;

  // Every asserted valid implies a transfer when credits allow, because the
  // requester only ever sees its ready once this grant is already decided.
  always_comb begin
    w_pick     = rr_pick(MAX_REQ'(i_reqValid), 32'(r_rrPtr), NUM_REQ);
    o_grantIdx = ID_W'(w_pick);
    o_transfer = (|i_reqValid) & i_issueOk;
    o_grant    = o_transfer ? (NUM_REQ'(1) << o_grantIdx) : '0;
  end

  // Pointer moves past the winner only on an actual transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rrPtr <= '0;
    end else if (o_transfer) begin
      r_rrPtr <= (o_grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : o_grantIdx + 1'b1;
    end
  end

endmodule

// File: rtl/hash_request_arbiter.sv
// hash_request_arbiter
//   Shares one Hashing_Unit among NUM_REQ key requesters. One key is accepted
//   per cycle by round robin, its id and key ride a shift register alongside
//   the hash pipeline, and results are buffered in a response FIFO. Keys are
//   only accepted while in-flight plus buffered results leave a FIFO slot
//   free, so back-pressure never loses a result.
//   Optional feature macro: HASH_ARB_STATS_EN adds grant_count and
//   stall_cycles statistics outputs.
//   Ports:
//     clock, reset  rising-edge clock, synchronous active-high reset
//     req_valid     per-requester key valid
//     req_key       per-requester 32-bit key
//     req_ready     one-hot grant; transfer on req_valid & req_ready
//     resp_valid    FIFO head valid
//     resp_id       requester index of the head result
//     resp_key      original key of the head result
//     resp_hash     hash of resp_key
//     resp_ready    consumer accepts the head result
//     grant_count   (stats) saturating accepted-key count per requester
//     stall_cycles  (stats) saturating count of cycles blocked by credits
module hash_request_arbiter
  import hash_arb_pkg::*;
#(
  parameter int NUM_REQ                    = 4,
  parameter int NUM_ENTRIES_PER_HASH_TABLE = 256,
  parameter int HASH_LATENCY               = 1,
  parameter int RESP_FIFO_DEPTH            = 4
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ-1:0][KEY_WIDTH-1:0]             req_key,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic                                          resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]                    resp_id,
  output logic [KEY_WIDTH-1:0]                          resp_key,
  output logic [$clog2(NUM_ENTRIES_PER_HASH_TABLE)-1:0] resp_hash,
`ifdef HASH_ARB_STATS_EN
  output logic [NUM_REQ-1:0][31:0]                      grant_count,
  output logic [31:0]                                   stall_cycles,
`endif
  input  logic                                          resp_ready
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int HASH_W = $clog2(NUM_ENTRIES_PER_HASH_TABLE);
  localparam int PTR_W  = $clog2(RESP_FIFO_DEPTH);
  localparam int CNT_W  = $clog2(RESP_FIFO_DEPTH + 1);

  logic [ID_W-1:0]      w_grantIdx;
  logic                 w_transfer;
  logic                 w_issueOk;
  logic [CNT_W:0]       w_occupancy;
  logic [KEY_WIDTH-1:0] w_hashKey;
  logic [HASH_W-1:0]    w_hashValue;
  logic                 w_capture;
  logic                 w_pop;
  hash_resp_t           w_pushEntry;
  hash_resp_t           w_head;
  logic                 w_unusedHead;

  logic                 r_pipeValid [HASH_LATENCY];
  logic [ID_W-1:0]      r_pipeId    [HASH_LATENCY];
  logic [KEY_WIDTH-1:0] r_pipeKey   [HASH_LATENCY];
  logic [CNT_W-1:0]     r_inflight;
  hash_resp_t           r_fifoMem   [RESP_FIFO_DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_fifoCount;

  // Every accepted key holds a credit until its result leaves the FIFO.
  always_comb begin
    w_occupancy = {1'b0, r_inflight} + {1'b0, r_fifoCount};
    w_issueOk   = w_occupancy < (CNT_W + 1)'(RESP_FIFO_DEPTH);
  end

  hash_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .clock      (clock),
    .reset      (reset),
    .i_reqValid (req_valid),
    .i_issueOk  (w_issueOk),
    .o_grant    (req_ready),
    .o_grantIdx (w_grantIdx),
    .o_transfer (w_transfer)
  );

  // Idle cycles feed zero so the hash unit sees no stray requester data.
  assign w_hashKey = w_transfer ? req_key[w_grantIdx] : '0;

  Hashing_Unit #(
    .NUM_ENTRIES_PER_HASH_TABLE (NUM_ENTRIES_PER_HASH_TABLE),
    .HASH_LATENCY               (HASH_LATENCY)
  ) u_hash (
    .clock      (clock),
    .reset      (reset),
    .key        (w_hashKey),
    .hash_value (w_hashValue)
  );

  // Valid bits of the side pipeline; reset drops everything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < HASH_LATENCY; s++) r_pipeValid[s] <= 1'b0;
    end else begin
      r_pipeValid[0] <= w_transfer;
      for (int s = 1; s < HASH_LATENCY; s++) r_pipeValid[s] <= r_pipeValid[s-1];
    end
  end

  // Id and key travel with the hash so the last stage lines up with hash_value.
  always_ff @(posedge clock) begin
    r_pipeId[0]  <= w_grantIdx;
    r_pipeKey[0] <= w_hashKey;
    for (int s = 1; s < HASH_LATENCY; s++) begin
      r_pipeId[s]  <= r_pipeId[s-1];
      r_pipeKey[s] <= r_pipeKey[s-1];
    end
  end

  always_comb begin
    w_capture              = r_pipeValid[HASH_LATENCY-1];
    w_pop                  = (r_fifoCount != '0) && resp_ready;
    w_pushEntry            = '0;
    w_pushEntry.id[ID_W-1:0]     = r_pipeId[HASH_LATENCY-1];
    w_pushEntry.key              = r_pipeKey[HASH_LATENCY-1];
    w_pushEntry.hash[HASH_W-1:0] = w_hashValue;
  end

  // Credits guarantee a free slot whenever a result arrives.
  always_ff @(posedge clock) begin
    if (w_capture) r_fifoMem[r_tail] <= w_pushEntry;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_fifoCount <= '0;
    end else begin
      if (w_capture) r_tail <= r_tail + 1'b1;
      if (w_pop)     r_head <= r_head + 1'b1;
      case ({w_capture, w_pop})
        2'b10:   r_fifoCount <= r_fifoCount + 1'b1;
        2'b01:   r_fifoCount <= r_fifoCount - 1'b1;
        default: r_fifoCount <= r_fifoCount;
      endcase
    end
  end

  // Keys between acceptance and FIFO capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= '0;
    end else begin
      case ({w_transfer, w_capture})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Outputs read as zero while the FIFO is empty, which also covers reset.
  always_comb begin
    w_head       = r_fifoMem[r_head];
    w_unusedHead = ^{w_head.id, w_head.hash};
    resp_valid   = (r_fifoCount != '0);
    resp_id      = resp_valid ? w_head.id[ID_W-1:0]     : '0;
    resp_key     = resp_valid ? w_head.key              : '0;
    resp_hash    = resp_valid ? w_head.hash[HASH_W-1:0] : '0;
  end

`ifdef HASH_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] r_grantCount;
  logic [31:0]              r_stallCycles;
  logic                     w_stall;

  assign w_stall = (|req_valid) & ~w_issueOk;

  // Saturating statistics counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grantCount  <= '0;
      r_stallCycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (r_grantCount[i] != 32'hFFFF_FFFF))
          r_grantCount[i] <= r_grantCount[i] + 32'd1;
      end
      if (w_stall && (r_stallCycles != 32'hFFFF_FFFF))
        r_stallCycles <= r_stallCycles + 32'd1;
    end
  end

  assign grant_count  = r_grantCount;
  assign stall_cycles = r_stallCycles;
`endif

endmodule

// File: tb/tb_hash_request_arbiter.sv
// tb_hash_request_arbiter
//   Self-checking bench for hash_request_arbiter. A queue-based reference
//   tracks accepted keys in order, the round-robin pointer and the credit
//   limit; each cycle the DUT outputs are compared against it. A table of
//   sparse-valid vectors and directed sequences cover the corner cases.
module tb_hash_request_arbiter;

  localparam int NUM_REQ = 4;
  localparam int NENT    = 256;
  localparam int LAT     = 1;
  localparam int DEPTH   = 4;
  localparam int HW      = 8;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_key;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic [1:0]               resp_id;
  logic [31:0]              resp_key;
  logic [HW-1:0]            resp_hash;
  logic                     resp_ready;
`ifdef HASH_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_count;
  logic [31:0]              stall_cycles;
`endif

  always #5 clock = ~clock;

  hash_request_arbiter #(
    .NUM_REQ                    (NUM_REQ),
    .NUM_ENTRIES_PER_HASH_TABLE (NENT),
    .HASH_LATENCY               (LAT),
    .RESP_FIFO_DEPTH            (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_key      (req_key),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_key     (resp_key),
    .resp_hash    (resp_hash),
`ifdef HASH_ARB_STATS_EN
    .grant_count  (grant_count),
    .stall_cycles (stall_cycles),
`endif
    .resp_ready   (resp_ready)
  );

  typedef struct {
    int          id;
    logic [31:0] key;
    logic [HW-1:0] hash;
    int          readyCycle;
  } exp_t;

  typedef struct {
    logic [3:0] valid;
    logic       respReady;
    logic [3:0] expReady;
  } vec_t;

  exp_t        expQ[$];
  int          rrPtr;
  int          cycleNum;
  int          checks;
  int          failures;
  logic [31:0] curKey [NUM_REQ];
  int          dutTransfers, dutPops, modelTransfers, modelPops;
  int          statGrants [NUM_REQ];
  int          statStalls;
  logic [NUM_REQ-1:0] seen;
  vec_t        vecs [9];

  function automatic logic [HW-1:0] refHash(input logic [31:0] k);
    logic [31:0] p;
    p = k * 32'h9E37_79B1;
    return p[31 -: HW];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleNum);
    end
  endtask

  // One clock of stimulus; expectations come from the in-order queue model.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic respReady,
                               input bit randKeys, output logic [NUM_REQ-1:0] seenReady);
    int g;
    bit issueOk, headValid;
    logic [NUM_REQ-1:0] expReady;
    exp_t e;
    req_valid  = valid;
    resp_ready = respReady;
    for (int i = 0; i < NUM_REQ; i++) req_key[i] = curKey[i];
    @(negedge clock);
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (rrPtr + k) % NUM_REQ;
      if (g < 0 && valid[idx]) g = idx;
    end
    issueOk  = (expQ.size() < DEPTH);
    expReady = '0;
    if (g >= 0 && issueOk) expReady[g] = 1'b1;
    headValid = (expQ.size() > 0) && (expQ[0].readyCycle <= cycleNum);
    seenReady = req_ready;
    checkOutput("req_ready", req_ready, expReady);
    checkOutput("resp_valid", resp_valid, headValid);
    if (headValid) begin
      checkOutput("resp_id", resp_id, expQ[0].id);
      checkOutput("resp_key", resp_key, expQ[0].key);
      checkOutput("resp_hash", resp_hash, expQ[0].hash);
    end
    if (|valid && !issueOk) statStalls++;
    if (|(req_valid & req_ready)) dutTransfers++;
    if (resp_valid && resp_ready) dutPops++;
    @(posedge clock);
    #1;
    if (headValid && respReady) begin
      void'(expQ.pop_front());
      modelPops++;
    end
    if (g >= 0 && issueOk) begin
      e.id         = g;
      e.key        = curKey[g];
      e.hash       = refHash(curKey[g]);
      e.readyCycle = cycleNum + LAT + 1;
      expQ.push_back(e);
      rrPtr = (g + 1) % NUM_REQ;
      statGrants[g]++;
      modelTransfers++;
      curKey[g] = randKeys ? $urandom : curKey[g] + 32'd1;
    end
    cycleNum++;
  endtask

  task automatic doReset();
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    expQ.delete();
    rrPtr      = 0;
    statStalls = 0;
    for (int i = 0; i < NUM_REQ; i++) statGrants[i] = 0;
    cycleNum++;
  endtask

  task automatic drainIdle();
    logic [NUM_REQ-1:0] s;
    for (int c = 0; c < 20 && expQ.size() > 0; c++) applyStimulus('0, 1'b1, 1'b0, s);
  endtask

  initial begin
    checks = 0; failures = 0; cycleNum = 0; rrPtr = 0;
    dutTransfers = 0; dutPops = 0; modelTransfers = 0; modelPops = 0;
    reset = 1'b1; req_valid = '0; req_key = '0; resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) curKey[i] = 32'h100 * i;

    // Reset values.
    doReset();
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_resp_valid", resp_valid, 0);
    checkOutput("reset_resp_id", resp_id, 0);
    checkOutput("reset_resp_key", resp_key, 0);
    checkOutput("reset_resp_hash", resp_hash, 0);

    // Single requester, keys 0..9 back to back.
    curKey[0] = 0;
    dutPops = 0;
    for (int c = 0; c < 10; c++) applyStimulus(4'b0001, 1'b1, 1'b0, seen);
    drainIdle();
    checkOutput("single_resp_count", dutPops, 10);

    // All requesters valid: grants rotate 0,1,2,3,...
    doReset();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, seen);
      checkOutput("rr_sequence", seen, 4'b0001 << (c % 4));
    end
    drainIdle();

    // Consumer stalled: exactly DEPTH keys get in, then ready drops.
    dutTransfers = 0;
    for (int c = 0; c < 8; c++) applyStimulus(4'b1111, 1'b0, 1'b0, seen);
    checkOutput("bp_transfers", dutTransfers, DEPTH);
    checkOutput("bp_ready_low", req_ready, 0);
    dutPops = 0; modelPops = 0; dutTransfers = 0; modelTransfers = 0;
    for (int c = 0; c < 8; c++) applyStimulus(4'b1111, 1'b1, 1'b0, seen);
    checkOutput("bp_drain_pops", dutPops, modelPops);
    checkOutput("bp_resume_transfers", dutTransfers, modelTransfers);
    drainIdle();

    // Sparse valids from a fresh pointer.
    vecs[0] = '{4'b1010, 1'b1, 4'b0010};
    vecs[1] = '{4'b1010, 1'b1, 4'b1000};
    vecs[2] = '{4'b1010, 1'b1, 4'b0010};
    vecs[3] = '{4'b0000, 1'b1, 4'b0000};
    vecs[4] = '{4'b1010, 1'b1, 4'b1000};
    vecs[5] = '{4'b1111, 1'b1, 4'b0001};
    vecs[6] = '{4'b1111, 1'b1, 4'b0010};
    vecs[7] = '{4'b0101, 1'b1, 4'b0100};
    vecs[8] = '{4'b0001, 1'b1, 4'b0001};
    doReset();
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].valid, vecs[v].respReady, 1'b0, seen);
      checkOutput($sformatf("vec%0d_ready", v), seen, vecs[v].expReady);
    end
    drainIdle();

    // Reset with results in flight and buffered: all of them vanish.
    for (int c = 0; c < 3; c++) applyStimulus(4'b1111, 1'b0, 1'b0, seen);
    doReset();
    checkOutput("midreset_resp_valid", resp_valid, 0);
    dutPops = 0;
    for (int c = 0; c < 10; c++) applyStimulus('0, 1'b1, 1'b0, seen);
    checkOutput("midreset_stale_pops", dutPops, 0);
    applyStimulus(4'b1111, 1'b1, 1'b0, seen);
    checkOutput("midreset_first_grant", seen, 4'b0001);
    drainIdle();

    // Randomised traffic and back-pressure.
    for (int c = 0; c < 400; c++)
      applyStimulus(NUM_REQ'($urandom), ($urandom_range(0, 3) != 0), 1'b1, seen);
    drainIdle();

`ifdef HASH_ARB_STATS_EN
    doReset();
    for (int c = 0; c < 40 && statGrants[2] < 7; c++) applyStimulus(4'b0100, 1'b1, 1'b0, seen);
    for (int c = 0; c < 40 && statGrants[0] < 3; c++) applyStimulus(4'b0001, 1'b1, 1'b0, seen);
    checkOutput("grant_count2", grant_count[2], 7);
    checkOutput("grant_count0", grant_count[0], 3);
    drainIdle();
    for (int c = 0; c < 8; c++) applyStimulus(4'b1111, 1'b0, 1'b0, seen);
    drainIdle();
    for (int i = 0; i < NUM_REQ; i++)
      checkOutput($sformatf("grant_count%0d_total", i), grant_count[i], statGrants[i]);
    checkOutput("stall_cycles", stall_cycles, statStalls);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
